// File: rtl/palette_ram_fx_if.sv
// rtl/palette_ram_fx_if.sv - host write, lookup read and sweep control bundle for palette_ram_fx
//
// Purpose: groups every palette_ram_fx signal except clock and reset.
// Parameters DATA_W, ADDR_W and NUM_RD must match the attached palette_ram_fx.
// Modports:
//   master - register bus / renderers / bench side: drives the *_i signals, observes the *_o signals
//   slave  - palette_ram_fx side
// Signals:
//   wr_en_i, ben_i, wr_addr_i, wr_data_i  host write port with byte enables
//   rd_en_i, rd_addr_i, rd_data_o         NUM_RD packed lookup ports, port k at slice k
//   clear_i, fill_i, fade_i               sweep requests
//   busy_o, done_o, wr_drop_o             sweep status and dropped-write pulse
interface palette_ram_fx_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NUM_RD = 2
);
  logic                       wr_en_i;
  logic [DATA_W/8-1:0]        ben_i;
  logic [ADDR_W-1:0]          wr_addr_i;
  logic [DATA_W-1:0]          wr_data_i;
  logic [NUM_RD-1:0]          rd_en_i;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i;
  logic [NUM_RD*DATA_W-1:0]   rd_data_o;
  logic                       clear_i;
  logic [DATA_W-1:0]          fill_i;
  logic                       fade_i;
  logic                       busy_o;
  logic                       done_o;
  logic                       wr_drop_o;

  modport master (
    output wr_en_i, ben_i, wr_addr_i, wr_data_i,
    output rd_en_i, rd_addr_i,
    output clear_i, fill_i, fade_i,
    input  rd_data_o, busy_o, done_o, wr_drop_o
  );

  modport slave (
    input  wr_en_i, ben_i, wr_addr_i, wr_data_i,
    input  rd_en_i, rd_addr_i,
    input  clear_i, fill_i, fade_i,
    output rd_data_o, busy_o, done_o, wr_drop_o
  );
endinterface

// File: rtl/palette_ram_fx.sv
// rtl/palette_ram_fx.sv - palette memory with byte-enabled host write, NUM_RD lookup ports and sweep engine
//
// Purpose: single-clock palette RAM for the video compositor. The host writes with byte
// enables while idle; every layer has its own registered lookup port that is served in all
// states. A sweep engine fills every entry with a latched value on clear_i and after reset.
// Optional feature macro: PALETTE_FADE_EN - adds a fade sweep (fade_i) that decrements every
// 4-bit nibble of every entry by one, saturating at zero.
// Ports:
//   clk_i    in  sole clock, rising edge
//   rst_n_i  in  asynchronous active-low reset; restarts a zero-fill sweep from address 0
//   bus      slave modport of palette_ram_fx_if (write port, read ports, sweep control/status)
module palette_ram_fx #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NUM_RD = 2
) (
  input logic             clk_i,
  input logic             rst_n_i,
  palette_ram_fx_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

`ifdef PALETTE_FADE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_FADE_RD, ST_FADE_WR} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q [NUM_RD];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;

  // Single shared write port: host writes only in IDLE, the sweep only outside IDLE,
  // so the two never compete in the same cycle.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [NB-1:0]     mem_ben;

`ifdef PALETTE_FADE_EN
  logic [DATA_W-1:0] fade_q;

  function automatic logic [DATA_W-1:0] fade_dec(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = v;
    for (int n = 0; n < DATA_W / 4; n++) begin
      if (v[4*n +: 4] != 4'd0) r[4*n +: 4] = v[4*n +: 4] - 4'd1;
    end
    return r;
  endfunction
`else
  logic unused_fade;
  assign unused_fade = bus.fade_i;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_CLEAR;
      addr_q  <= '0;
      fill_q  <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    fill_d   = fill_q;
    done_d   = 1'b0;
    drop_d   = bus.wr_en_i && (state_q != ST_IDLE);
    mem_we   = 1'b0;
    mem_addr = addr_q;
    mem_data = fill_q;
    mem_ben  = '1;
    case (state_q)
      ST_IDLE: begin
        // A host write in the same cycle as clear_i still commits; the sweep overwrites it later.
        if (bus.wr_en_i) begin
          mem_we   = 1'b1;
          mem_addr = bus.wr_addr_i;
          mem_data = bus.wr_data_i;
          mem_ben  = bus.ben_i;
        end
        if (bus.clear_i) begin
          fill_d  = bus.fill_i;
          addr_d  = '0;
          state_d = ST_CLEAR;
        end
`ifdef PALETTE_FADE_EN
        else if (bus.fade_i) begin
          addr_d  = '0;
          state_d = ST_FADE_RD;
        end
`endif
      end
      ST_CLEAR: begin
        mem_we = 1'b1;
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`ifdef PALETTE_FADE_EN
      ST_FADE_RD: state_d = ST_FADE_WR;
      ST_FADE_WR: begin
        mem_we   = 1'b1;
        mem_data = fade_dec(fade_q);
        addr_d   = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FADE_RD;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage is never reset; the post-reset sweep initialises it.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_ben[b]) mem[mem_addr][8*b +: 8] <= mem_data[8*b +: 8];
      end
    end
`ifdef PALETTE_FADE_EN
    // Internal read port used only by the fade sweep.
    if (state_q == ST_FADE_RD) fade_q <= mem[addr_q];
`endif
  end

  // Lookup ports sample the array before this cycle's write lands, so a same-address
  // read/write returns the old entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_RD; k++) rd_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (bus.rd_en_i[k]) rd_q[k] <= mem[bus.rd_addr_i[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign bus.rd_data_o[k*DATA_W +: DATA_W] = rd_q[k];
  end

  assign bus.busy_o    = (state_q != ST_IDLE);
  assign bus.done_o    = done_q;
  assign bus.wr_drop_o = drop_q;
endmodule
